mtm_alu_core_sequencer: RTL and testbench
=========================================

// Module: mtm_alu_core_sequencer
// PURPOSE
//  Sits between the frame deserializer and the ALU core. Accepts one decoded command
//  (A, B, OP) or one pre-built error CTL frame per transaction and issues it to the ALU.
//  Waits for the result, computes the 3-bit result CRC and hands the result or error
//  frame to the output serializer over a valid/ready handshake.
// PARAMETERS
//  DATA_W       32  operand/result width
//  TIMEOUT_CYC  64  max WAIT cycles before abort (used only with MTM_ALU_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous active-high reset
//  req_valid    in   1       command/error frame valid from deserializer
//  req_ready    out  1       sequencer can accept (high only in IDLE)
//  req_A        in   DATA_W  operand A
//  req_B        in   DATA_W  operand B
//  req_op       in   3       opcode (pre-validated upstream)
//  req_err      in   1       1 = error transaction, forward req_ctl, skip ALU
//  req_ctl      in   8       error CTL frame, meaningful when req_err=1
//  alu_start    out  1       one-cycle issue pulse to ALU core
//  alu_A        out  DATA_W  ALU operand A
//  alu_B        out  DATA_W  ALU operand B
//  alu_op       out  3       ALU opcode
//  alu_done     in   1       ALU result valid (one-cycle pulse)
//  alu_C        in   DATA_W  ALU result
//  alu_flags    in   4       ALU flags {carry, overflow, zero, negative}
//  rsp_valid    out  1       response valid to serializer
//  rsp_ready    in   1       serializer accepts response
//  rsp_is_err   out  1       1 = rsp_ctl is an error frame, rsp_C is don't-care (driven 0)
//  rsp_C        out  DATA_W  result word
//  rsp_ctl      out  8       CTL frame: data {1'b0, flags[3:0], crc3[2:0]} or error frame
//  ops_cnt      out  16      completed-transaction counter, wraps at 16'hFFFF -> 0
//  timeout_err  out  1       one-cycle pulse on ALU timeout (constant 0 without macro)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE. Async assert aborts any transaction; alu_start drops immediately.
//  - FSM: IDLE -> (req_valid & req_ready) -> ISSUE if !req_err, SEND if req_err.
//    ISSUE (1 cycle) -> WAIT -> alu_done -> PACK (1 cycle) -> SEND -> rsp_ready -> IDLE.
//  - IDLE: req_ready=1. Capture req_* on accept. In error transactions, rsp_ctl<=req_ctl and rsp_is_err<=1.
//  - ISSUE: alu_start=1 for exactly 1 cycle. alu_A/B/op are held from ISSUE until IDLE is re-entered.
//  - WAIT: alu_done sampled only here; alu_done in any other state is ignored.
//  - PACK: rsp_C<=alu_C (captured at alu_done), rsp_ctl<={1'b0, flags, crc3}, rsp_is_err<=0.
//  - CRC3: polynomial x^3+x+1, init 000, over 37 bits {C[31:0], 1'b0, flags[3:0]}, MSB first.
//    Result = remainder of M(x)*x^3.
//  - SEND: rsp_valid=1. rsp_* stay stable until rsp_ready. On transfer, ops_cnt+=1 and return to IDLE.
//    rsp_valid is 0 in the following cycle.
//  - Latency: accept at cycle N, alu_start at N+1, alu_done at M, rsp_valid from M+2. Error path: rsp_valid at N+1.
//  - Back-to-back: req_ready is 1 in the first IDLE cycle after the response transfer; no bubble beyond that cycle.
// CONFIGURATION
//  - `MTM_ALU_SEQ_TIMEOUT_EN defined: a WAIT-cycle counter starts at ISSUE.
//    If TIMEOUT_CYC cycles elapse in WAIT with no alu_done: pulse timeout_err,
//    set rsp_ctl=8'h86 (data error frame) and rsp_is_err=1, then go to SEND.
//    If alu_done arrives in the expiry cycle, done wins.
//  - Macro not defined: WAIT is unbounded, no counter is built, timeout_err is tied to 0.
// STRUCTURE
//  - Package mtm_alu_pkg holds: FSM state encoding (IDLE, ISSUE, WAIT, PACK, SEND), opcodes
//    (AND 000, OR 001, ADD 100, SUB 101), CTL constants (CTL_ERR_DATA=8'h86), CRC3 polynomial.
//  - Sub-module mtm_alu_crc3: combinational 37-bit -> 3-bit CRC, instantiated once.
// TESTING (ALU stub with programmable latency)
//  1. AND A=0, B=0, stub C=0, flags=0, latency 3 -> rsp_C=0, rsp_ctl=8'h00, rsp_valid 2 cycles after alu_done.
//  2. ADD A=1, B=2, stub C=3, flags=0 -> alu_start single pulse, rsp_C=32'h3, rsp_ctl=8'h06, ops_cnt=1.
//  3. req_err=1, req_ctl=8'hC9 -> no alu_start, rsp_is_err=1, rsp_ctl=8'hC9 at N+1.
//  4. Hold rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0, spurious alu_done ignored.
//     Release -> IDLE, req_ready=1.
//  5. Async rst asserted in WAIT -> all outputs 0 immediately. Next transaction completes normally.
//  6. Macro on, stub never completes -> timeout_err pulse after 64 WAIT cycles, rsp_ctl=8'h86.
//     Macro off -> sequencer stays in WAIT.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the MTM ALU sequencer.
// FSM encoding, opcodes, CTL frame constants, CRC3 polynomial.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PACK,
    S_SEND
  } seq_state_t;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } alu_op_t;

  localparam logic [7:0] CTL_ERR_DATA = 8'h86;

  // x^3 + x + 1
  localparam logic [3:0] CRC3_POLY = 4'b1011;

  // {C[31:0], 1'b0, flags[3:0]}
  localparam int CRC3_MSG_W = 37;

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC3 (x^3+x+1, init 0) over the
// 37-bit result message, MSB first.
module mtm_alu_crc3
  import mtm_alu_pkg::*;
(
  input  logic [CRC3_MSG_W-1:0] msg,
  output logic [2:0]            crc
);

  logic [2:0] r;
  logic       fb;

  // Unrolled serial LFSR: remainder of M(x)*x^3
  always_comb begin
    r  = 3'b000;
    fb = 1'b0;
    for (int i = CRC3_MSG_W - 1; i >= 0; i--) begin
      fb = r[2] ^ msg[i];
      r  = {r[1:0], 1'b0} ^ ({3{fb}} & CRC3_POLY[2:0]);
    end
    crc = r;
  end

endmodule

// File: rtl/mtm_alu_core_sequencer.sv
// Issues one command per transaction to the ALU and returns
// result/error frames. Optional: MTM_ALU_SEQ_TIMEOUT_EN.
module mtm_alu_core_sequencer
  import mtm_alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_A,
  input  logic [DATA_W-1:0] req_B,
  input  logic [2:0]        req_op,
  input  logic              req_err,
  input  logic [7:0]        req_ctl,
  output logic              alu_start,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [2:0]        alu_op,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_C,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_is_err,
  output logic [DATA_W-1:0] rsp_C,
  output logic [7:0]        rsp_ctl,
  output logic [15:0]       ops_cnt,
  output logic              timeout_err
);

  seq_state_t        state;
  seq_state_t        state_n;
  logic [DATA_W-1:0] c_q;
  logic [3:0]        flags_q;
  logic [2:0]        crc3;
  logic              accept;
  logic              done_hit;
  logic              wait_expired;

  assign accept    = (state == S_IDLE) && req_valid;
  assign done_hit  = (state == S_WAIT) && alu_done;
  assign req_ready = (state == S_IDLE) && !rst;
  assign alu_start = (state == S_ISSUE);
  assign rsp_valid = (state == S_SEND);

  mtm_alu_crc3 u_crc3 (
    .msg ({c_q, 1'b0, flags_q}),
    .crc (crc3)
  );

`ifdef MTM_ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Done in the expiry cycle takes priority
  assign wait_expired = (state == S_WAIT) &&
                        !alu_done &&
                        (wait_cnt == CNT_LAST);

  // WAIT-cycle counter, cleared in ISSUE; pulse on expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wait_expired;
      if (state == S_ISSUE)
        wait_cnt <= '0;
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg   = ^TIMEOUT_CYC;
  assign wait_expired = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (req_valid)
          state_n = req_err ? S_SEND : S_ISSUE;
      S_ISSUE:
        state_n = S_WAIT;
      S_WAIT:
        if (alu_done)
          state_n = S_PACK;
        else if (wait_expired)
          state_n = S_SEND;
      S_PACK:
        state_n = S_SEND;
      S_SEND:
        if (rsp_ready)
          state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // Operand capture, result packing, response regs, counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_A      <= '0;
      alu_B      <= '0;
      alu_op     <= '0;
      c_q        <= '0;
      flags_q    <= '0;
      rsp_C      <= '0;
      rsp_ctl    <= '0;
      rsp_is_err <= 1'b0;
      ops_cnt    <= '0;
    end else begin
      if (accept && !req_err) begin
        alu_A  <= req_A;
        alu_B  <= req_B;
        alu_op <= req_op;
      end
      if (accept && req_err) begin
        rsp_C      <= '0;
        rsp_ctl    <= req_ctl;
        rsp_is_err <= 1'b1;
      end
      if (done_hit) begin
        c_q     <= alu_C;
        flags_q <= alu_flags;
      end
      if (state == S_PACK) begin
        rsp_C      <= c_q;
        rsp_ctl    <= {1'b0, flags_q, crc3};
        rsp_is_err <= 1'b0;
      end
      if (wait_expired) begin
        rsp_C      <= '0;
        rsp_ctl    <= CTL_ERR_DATA;
        rsp_is_err <= 1'b1;
      end
      if ((state == S_SEND) && rsp_ready)
        ops_cnt <= ops_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mtm_alu_core_sequencer.sv
// Scoreboard bench for mtm_alu_core_sequencer with an
// ALU stub of programmable latency.
module tb_mtm_alu_core_sequencer;

  typedef struct {
    logic        err;
    logic [31:0] c;
    logic [7:0]  ctl;
    int          lk;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_A;
  logic [31:0] req_B;
  logic [2:0]  req_op;
  logic        req_err;
  logic [7:0]  req_ctl;
  logic        alu_start;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [31:0] alu_C;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_is_err;
  logic [31:0] rsp_C;
  logic [7:0]  rsp_ctl;
  logic [15:0] ops_cnt;
  logic        timeout_err;

  int checks;
  int errors;
  int cyc;
  int acc_cyc;
  int done_cyc;
  int starts;
  int exp_ops;
  logic prev_valid;
  logic chk_ops;
  exp_t q[$];

  logic [31:0] stub_c;
  logic [3:0]  stub_f;
  int          stub_lat;
  logic        stub_hang;
  logic        spur;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [2:0]  exp_op;

  mtm_alu_core_sequencer #(
    .DATA_W      (32),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_A       (req_A),
    .req_B       (req_B),
    .req_op      (req_op),
    .req_err     (req_err),
    .req_ctl     (req_ctl),
    .alu_start   (alu_start),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_op      (alu_op),
    .alu_done    (alu_done),
    .alu_C       (alu_C),
    .alu_flags   (alu_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_is_err  (rsp_is_err),
    .rsp_C       (rsp_C),
    .rsp_ctl     (rsp_ctl),
    .ops_cnt     (ops_cnt),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] crc_model(
    input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=1 exp=0");
    $fatal(1, "watchdog");
  end

  // ALU stub
  initial begin
    int cnt;
    logic busy;
    cnt = 0;
    busy = 0;
    alu_done = 0;
    alu_C = 0;
    alu_flags = 0;
    forever begin
      @(negedge clk);
      alu_done = 0;
      if (rst) begin
        busy = 0;
      end else begin
        if (spur) begin
          alu_done = 1;
          spur = 0;
        end else if (busy) begin
          if (cnt == 0) begin
            alu_done = 1;
            alu_C = stub_c;
            alu_flags = stub_f;
            done_cyc = cyc;
            busy = 0;
          end else cnt--;
        end
        if (alu_start) begin
          starts++;
          chk("alu_A", alu_A, exp_a);
          chk("alu_B", alu_B, exp_b);
          chk("alu_op", alu_op, exp_op);
          busy = !stub_hang;
          cnt = stub_lat - 1;
        end
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (chk_ops) begin
          chk("ops_cnt", ops_cnt, exp_ops);
          chk("valid_drop", rsp_valid, 0);
          chk("b2b_ready", req_ready, 1);
          chk_ops = 0;
        end
        if (rsp_valid && !prev_valid &&
            q.size() > 0) begin
          if (q[0].lk == 0)
            chk("lat_done", cyc - done_cyc, 2);
          else if (q[0].lk == 1)
            chk("lat_err", cyc - acc_cyc, 1);
        end
        if (rsp_valid && rsp_ready) begin
          if (q.size() == 0) begin
            chk("rsp_unexp", 0, 1);
          end else begin
            e = q.pop_front();
            chk("rsp_is_err", rsp_is_err, e.err);
            chk("rsp_C", rsp_C, e.c);
            chk("rsp_ctl", rsp_ctl, e.ctl);
          end
          exp_ops = (exp_ops + 1) & 16'hFFFF;
          chk_ops = 1;
        end
        prev_valid = rsp_valid;
      end
    end
  end

  task automatic push(input logic err,
                      input logic [31:0] c,
                      input logic [7:0] ctl,
                      input int lk);
    exp_t e;
    e.err = err;
    e.c = c;
    e.ctl = ctl;
    e.lk = lk;
    q.push_back(e);
  endtask

  task automatic send(input logic err,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [2:0] op,
                      input logic [7:0] ctl,
                      input logic [31:0] c,
                      input logic [3:0] f,
                      input int lat,
                      input logic hang);
    @(negedge clk);
    for (int i = 0; i < 300 && !req_ready; i++)
      @(negedge clk);
    chk("req_ready_wait", req_ready, 1);
    stub_c = c;
    stub_f = f;
    stub_lat = lat;
    stub_hang = hang;
    exp_a = a;
    exp_b = b;
    exp_op = op;
    req_A = a;
    req_B = b;
    req_op = op;
    req_err = err;
    req_ctl = ctl;
    req_valid = 1;
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 &&
         (q.size() != 0 || rsp_valid); i++)
      @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  task automatic reset_checks(input string t);
    chk({t, "_req_ready"}, req_ready, 0);
    chk({t, "_alu_start"}, alu_start, 0);
    chk({t, "_alu_A"}, alu_A, 0);
    chk({t, "_alu_B"}, alu_B, 0);
    chk({t, "_alu_op"}, alu_op, 0);
    chk({t, "_rsp_valid"}, rsp_valid, 0);
    chk({t, "_rsp_is_err"}, rsp_is_err, 0);
    chk({t, "_rsp_C"}, rsp_C, 0);
    chk({t, "_rsp_ctl"}, rsp_ctl, 0);
    chk({t, "_ops_cnt"}, ops_cnt, 0);
    chk({t, "_timeout"}, timeout_err, 0);
  endtask

  task automatic clear_sb();
    q.delete();
    exp_ops = 0;
    prev_valid = 0;
    chk_ops = 0;
    stub_hang = 0;
  endtask

  initial begin
    int s0;
    logic [31:0] rc;
    logic [3:0] rf;
    checks = 0;
    errors = 0;
    starts = 0;
    exp_ops = 0;
    prev_valid = 0;
    chk_ops = 0;
    spur = 0;
    rst = 1;
    req_valid = 0;
    req_A = 0;
    req_B = 0;
    req_op = 0;
    req_err = 0;
    req_ctl = 0;
    rsp_ready = 1;
    stub_c = 0;
    stub_f = 0;
    stub_lat = 1;
    stub_hang = 0;
    exp_a = 0;
    exp_b = 0;
    exp_op = 0;
    acc_cyc = 0;
    done_cyc = 0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst = 0;

    // 1: AND 0,0 latency 3
    push(0, 32'h0, 8'h00, 0);
    send(0, 0, 0, 3'b000, 0, 0, 0, 3, 0);
    drain();

    // 2: ADD 1+2, single start pulse
    s0 = starts;
    push(0, 32'h3, 8'h06, 0);
    send(0, 1, 2, 3'b100, 0, 3, 0, 2, 0);
    drain();
    chk("start_once", starts - s0, 1);

    // 3: error frame passthrough
    s0 = starts;
    push(1, 32'h0, 8'hC9, 1);
    send(1, 32'h55, 32'h66, 3'b001, 8'hC9,
         0, 0, 1, 0);
    drain();
    chk("err_no_start", starts - s0, 0);

    // back-to-back random commands
    for (int k = 0; k < 5; k++) begin
      rc = $urandom;
      rf = 4'($urandom_range(0, 15));
      push(0, rc, {1'b0, rf, crc_model(rc, rf)}, 0);
      send(0, $urandom, $urandom, 3'b101, 0, rc, rf,
           $urandom_range(1, 4), 0);
    end
    drain();

    // 4: backpressure, spurious done ignored
    @(posedge clk);
    #1 rsp_ready = 0;
    rc = 32'hDEAD_BEEF;
    rf = 4'b1010;
    push(0, rc, {1'b0, rf, crc_model(rc, rf)}, 0);
    send(0, 32'h7, 32'h9, 3'b001, 0, rc, rf, 2, 0);
    for (int i = 0; i < 50 && !rsp_valid; i++)
      @(negedge clk);
    chk("bp_valid", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) spur = 1;
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_C", rsp_C, rc);
      chk("bp_hold_ctl", rsp_ctl,
          {1'b0, rf, crc_model(rc, rf)});
      chk("bp_req_ready", req_ready, 0);
      chk("bp_ops", ops_cnt, exp_ops);
    end
    @(posedge clk);
    #1 rsp_ready = 1;
    drain();
    @(negedge clk);
    chk("bp_idle_ready", req_ready, 1);

    // 5: async reset in WAIT
    send(0, 32'h11, 32'h22, 3'b100, 0, 0, 0, 1, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 rst = 1;
    #1 reset_checks("arst");
    clear_sb();
    repeat (2) @(negedge clk);
    rst = 0;
    push(0, 32'h3, 8'h06, 0);
    send(0, 1, 2, 3'b100, 0, 3, 0, 3, 0);
    drain();

    // 6: ALU never completes
`ifdef MTM_ALU_SEQ_TIMEOUT_EN
    push(1, 32'h0, 8'h86, 2);
    send(0, 32'h4, 32'h5, 3'b000, 0, 0, 0, 1, 1);
    for (int i = 0; i < 200 && !timeout_err; i++)
      @(negedge clk);
    chk("to_pulse", timeout_err, 1);
    chk("to_cycle", cyc - acc_cyc, 66);
    @(negedge clk);
    chk("to_one_cycle", timeout_err, 0);
    drain();
`else
    send(0, 32'h4, 32'h5, 3'b000, 0, 0, 0, 1, 1);
    repeat (100) @(negedge clk);
    chk("hang_valid", rsp_valid, 0);
    chk("hang_ready", req_ready, 0);
    chk("hang_timeout", timeout_err, 0);
    rst = 1;
    clear_sb();
    repeat (2) @(negedge clk);
    rst = 0;
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
